text_writer: RTL and testbench

TEXT_WRITER -- requirements
Module: text_writer

---
 rtl/text_writer.sv | 174 +++++++++++++++++
 tb/tb_text_writer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_writer.sv
// Character-stream text writer: turns a byte stream into text-buffer
// cell writes with cursor tracking, line clearing and full-screen clear.
module text_writer #(
  parameter int          COLS  = 80,
  parameter int          ROWS  = 60,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic [7:0]  color,
  input  logic        clear_req,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [15:0] wr_data,
  input  logic        wr_grant,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLR_LINE,
    CLR_SCREEN
  } state_t;

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [15:0] BLANK_W   = {8'h00, BLANK};

  state_t      state_q, state_n;
  logic [6:0]  col_q, col_n;
  logic [5:0]  row_q, row_n;
  logic [6:0]  acol_q, acol_n;
  logic [5:0]  arow_q, arow_n;
  logic [15:0] data_q, data_n;
  logic        bs_q, bs_n;
  logic        live_q;

  logic        accept;
  logic        printable;
  logic        done;
  logic [5:0]  row_inc;

  assign char_ready = live_q && (state_q == IDLE) && !clear_req;
  assign wr_en      = (state_q != IDLE);
  assign wr_addr    = {1'b0, arow_q, acol_q};
  assign wr_data    = data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  assign accept    = char_valid && char_ready;
  assign printable = (char_data >= 8'h20) && (char_data <= 8'h7E);
  assign done      = wr_en && wr_grant;
  assign row_inc   = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      acol_q  <= '0;
      arow_q  <= '0;
      data_q  <= '0;
      bs_q    <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      col_q   <= col_n;
      row_q   <= row_n;
      acol_q  <= acol_n;
      arow_q  <= arow_n;
      data_q  <= data_n;
      bs_q    <= bs_n;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_n = state_q;
    col_n   = col_q;
    row_n   = row_q;
    acol_n  = acol_q;
    arow_n  = arow_q;
    data_n  = data_q;
    bs_n    = bs_q;
    case (state_q)
      IDLE: begin
        if (live_q && clear_req) begin
          state_n = CLR_SCREEN;
          arow_n  = '0;
          acol_n  = '0;
          data_n  = BLANK_W;
        end else if (accept) begin
          unique case (1'b1)
            printable: begin
              state_n = WRITE;
              arow_n  = row_q;
              acol_n  = col_q;
              data_n  = {color, char_data};
              bs_n    = 1'b0;
            end
            (char_data == 8'h0A): begin
              state_n = CLR_LINE;
              col_n   = '0;
              row_n   = row_inc;
              arow_n  = row_inc;
              acol_n  = '0;
              data_n  = BLANK_W;
            end
            (char_data == 8'h0D): begin
              col_n = '0;
            end
            (char_data == 8'h08 && col_q != 7'd0): begin
              state_n = WRITE;
              col_n   = col_q - 7'd1;
              arow_n  = row_q;
              acol_n  = col_q - 7'd1;
              data_n  = BLANK_W;
              bs_n    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        if (done) begin
          if (bs_q) begin
            state_n = IDLE;
          end else if (col_q == LAST_COL) begin
            // line wrap clears the freshly entered row
            state_n = CLR_LINE;
            col_n   = '0;
            row_n   = row_inc;
            arow_n  = row_inc;
            acol_n  = '0;
            data_n  = BLANK_W;
          end else begin
            state_n = IDLE;
            col_n   = col_q + 7'd1;
          end
        end
      end
      CLR_LINE: begin
        if (done) begin
          if (acol_q == LAST_COL) state_n = IDLE;
          else acol_n = acol_q + 7'd1;
        end
      end
      CLR_SCREEN: begin
        if (done) begin
          if (acol_q == LAST_COL) begin
            acol_n = '0;
            if (arow_q == LAST_ROW) begin
              state_n = IDLE;
              arow_n  = '0;
              col_n   = '0;
              row_n   = '0;
            end else begin
              arow_n = arow_q + 6'd1;
            end
          end else begin
            acol_n = acol_q + 7'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: queue-based model of expected cell writes
// and cursor, with directed byte sequences and literal spot checks.
module tb_text_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        char_ready;
  logic [7:0]  color = 8'h00;
  logic        clear_req = 1'b0;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_grant = 1'b1;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;

  text_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .color      (color),
    .clear_req  (clear_req),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_grant   (wr_grant),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0] a;
    logic [15:0] d;
  } wr_t;

  int          total = 0;
  int          bad = 0;
  int          nwr = 0;
  int          mcol = 0;
  int          mrow = 0;
  wr_t         expq[$];
  logic [13:0] last_addr = '0;
  logic [15:0] last_data = '0;
  logic        hold_v = 1'b0;
  logic [13:0] hold_a;
  logic [15:0] hold_d;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic void push_wr(int r, int c, logic [15:0] d);
    wr_t e;
    e.a = 14'(r * 128 + c);
    e.d = d;
    expq.push_back(e);
  endfunction

  function automatic void push_line(int r);
    for (int c = 0; c < 80; c++) push_wr(r, c, 16'h0020);
  endfunction

  function automatic void model_byte(logic [7:0] b, logic [7:0] at);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(mrow, mcol, {at, b});
      if (mcol < 79) mcol++;
      else begin
        mcol = 0;
        mrow = (mrow + 1) % 60;
        push_line(mrow);
      end
    end else if (b == 8'h0A) begin
      mcol = 0;
      mrow = (mrow + 1) % 60;
      push_line(mrow);
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h08 && mcol > 0) begin
      mcol--;
      push_wr(mrow, mcol, 16'h0020);
    end
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (char_valid && char_ready) model_byte(char_data, color);
      if (hold_v) begin
        chk("hold_en", int'(wr_en), 1);
        chk("hold_addr", int'(wr_addr), int'(hold_a));
        chk("hold_data", int'(wr_data), int'(hold_d));
      end
      hold_v = 1'b0;
      if (wr_en) begin
        if (wr_grant) begin
          total++;
          if (expq.size() == 0) begin
            bad++;
            $display("FAIL extra_write: got addr %0d want none",
                     wr_addr);
          end else begin
            total--;
            e = expq.pop_front();
            chk("wr_addr", int'(wr_addr), int'(e.a));
            chk("wr_data", int'(wr_data), int'(e.d));
          end
          nwr++;
          last_addr = wr_addr;
          last_data = wr_data;
        end else begin
          hold_v = 1'b1;
          hold_a = wr_addr;
          hold_d = wr_data;
        end
      end
    end
  end

  task automatic send(logic [7:0] b, logic [7:0] c);
    int k = 0;
    char_data  = b;
    color      = c;
    char_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (char_ready) break;
      k++;
      if (k > 6000) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (!(char_ready && expq.size() == 0)) begin
      @(negedge clk);
      k++;
      if (k > 6000) begin
        chk("idle_timeout", 1, 0);
        break;
      end
    end
    chk("cur_col", int'(cursor_col), mcol);
    chk("cur_row", int'(cursor_row), mrow);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int k;
    #23;
    chk("rst_ready", int'(char_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_col", int'(cursor_col), 0);
    chk("rst_row", int'(cursor_row), 0);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", int'(char_ready), 1);

    send(8'h41, 8'h1C);
    wait_idle();
    chk("a_count", nwr, 1);
    chk("a_addr", int'(last_addr), 0);
    chk("a_data", int'(last_data), 16'h1C41);
    chk("a_col", int'(cursor_col), 1);

    send(8'h0D, 8'h00);
    wait_idle();
    n0 = nwr;
    for (int i = 0; i < 80; i++) send(8'(8'h21 + i), 8'h07);
    wait_idle();
    chk("wrap_count", nwr - n0, 160);
    chk("wrap_last", int'(last_addr), 207);
    chk("wrap_row", int'(cursor_row), 1);

    for (int i = 0; i < 58; i++) send(8'h0A, 8'h00);
    for (int i = 0; i < 5; i++) send(8'(8'h61 + i), 8'h2A);
    send(8'h01, 8'h00);
    wait_idle();
    chk("pos_col", int'(cursor_col), 5);
    chk("pos_row", int'(cursor_row), 59);
    n0 = nwr;
    send(8'h0A, 8'h00);
    wait_idle();
    chk("lf59_count", nwr - n0, 80);
    chk("lf59_last", int'(last_addr), 79);
    chk("lf59_row", int'(cursor_row), 0);

    n0 = nwr;
    wr_grant = 1'b0;
    send(8'h5A, 8'h3C);
    repeat (3) @(posedge clk);
    #1 wr_grant = 1'b1;
    @(posedge clk);
    #1 wr_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1 wr_grant = 1'b1;
    wait_idle();
    chk("stall_count", nwr - n0, 1);
    chk("stall_data", int'(last_data), 16'h3C5A);

    n0 = nwr;
    send(8'h08, 8'h00);
    wait_idle();
    chk("bs_count", nwr - n0, 1);
    chk("bs_data", int'(last_data), 16'h0020);
    chk("bs_col", int'(cursor_col), 0);

    n0 = nwr;
    clear_req  = 1'b1;
    char_data  = 8'h51;
    color      = 8'h0F;
    char_valid = 1'b1;
    for (int r = 0; r < 60; r++) push_line(r);
    mcol = 0;
    mrow = 0;
    @(posedge clk);
    #1 clear_req = 1'b0;
    k = 0;
    forever begin
      @(negedge clk);
      if (char_ready) break;
      k++;
      if (k > 6000) begin
        chk("clr_timeout", 1, 0);
        break;
      end
    end
    chk("clr_count", nwr - n0, 4800);
    chk("clr_col", int'(cursor_col), 0);
    chk("clr_row", int'(cursor_row), 0);
    @(posedge clk);
    #1 char_valid = 1'b0;
    wait_idle();

    send(8'h0D, 8'h00);
    for (int i = 0; i < 3; i++) send(8'h0A, 8'h00);
    wait_idle();
    n0 = nwr;
    send(8'h08, 8'h00);
    send(8'h0D, 8'h00);
    wait_idle();
    chk("bscr_count", nwr - n0, 0);
    chk("bscr_col", int'(cursor_col), 0);
    chk("bscr_row", int'(cursor_row), 3);

    send(8'h0A, 8'h00);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_col", int'(cursor_col), 0);
    chk("abort_row", int'(cursor_row), 0);
    chk("abort_ready", int'(char_ready), 0);
    expq.delete();
    mcol = 0;
    mrow = 0;
    n0 = nwr;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_writes", nwr - n0, 0);
    chk("post_rst_ready", int'(char_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
